tap_controller: RTL

IEEE 1149.1-style TAP state machine that drives the scan-path control lines for the instruction register, the scan blocks and the bypass register. It sits directly upstream of those registers. It decodes the serial `tms` stream into one-cycle capture, shift and update enables, steers them to the data register selected by the current instruction, and muxes the returning serial data onto `tdo`.

---
 rtl/tap_controller.sv | 116 +++++++++++
 1 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: decodes tms into IR/DR capture, shift and
// update enables, steers DR enables by instruction and muxes tdo.
module tap_controller #(
  parameter int IR_WIDTH = 2,
  localparam int NDR = 2 ** IR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tms,
  input  logic [IR_WIDTH-1:0] instruction,
  input  logic                ir_tdo,
  input  logic [NDR-1:0]      dr_tdo,
  output logic                scan_reset,
  output logic                ir_capture,
  output logic                ir_shift,
  output logic                ir_update,
  output logic [NDR-1:0]      dr_capture,
  output logic [NDR-1:0]      dr_shift,
  output logic [NDR-1:0]      dr_update,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PA_DR  = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PA_IR  = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } state_t;

  state_t state_q, state_d;
  logic [NDR-1:0] sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= TLR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PA_DR;
      PA_DR:  state_d = tms ? EX2_DR : PA_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PA_IR;
      PA_IR:  state_d = tms ? EX2_IR : PA_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  assign sel   = {{(NDR-1){1'b0}}, 1'b1} << instruction;
  assign state = state_q;

  // Moore decodes only; TLR holds every capture/update enable high so that
  // downstream registers, which reset only while enabled, load reset values.
  always_comb begin
    scan_reset = 1'b0;
    ir_capture = 1'b0;
    ir_shift   = 1'b0;
    ir_update  = 1'b0;
    dr_capture = '0;
    dr_shift   = '0;
    dr_update  = '0;
    tdo        = 1'b0;
    tdo_en     = 1'b0;
    case (state_q)
      TLR: begin
        scan_reset = 1'b1;
        ir_capture = 1'b1;
        ir_update  = 1'b1;
        dr_capture = '1;
        dr_update  = '1;
      end
      CAP_IR: ir_capture = 1'b1;
      SH_IR: begin
        ir_shift = 1'b1;
        tdo      = ir_tdo;
        tdo_en   = 1'b1;
      end
      UPD_IR: ir_update = 1'b1;
      CAP_DR: dr_capture = sel;
      SH_DR: begin
        dr_shift = sel;
        tdo      = dr_tdo[instruction];
        tdo_en   = 1'b1;
      end
      UPD_DR: dr_update = sel;
      default: ;
    endcase
  end

endmodule
